// File: rtl/uart_stream_fmt.sv
// uart_stream_fmt -- buffered byte-stream formatter between a UART receiver
// and a UART transmitter.
//
// Received bytes are queued in a DEPTH-entry FIFO. Each byte is then sent as
// one of the following:
//   - raw echo (mode 0 and 3),
//   - two ASCII hex digits followed by a space (mode 1),
//   - two ASCII hex digits followed by a space, or by CR/LF after every
//     BYTES_PER_LINE bytes (mode 2).
//
// Optional feature: define HEX_LOWER_EN to emit hex digits a-f instead of A-F.
//
// Ports:
//   i_clk, i_rst_n    clock; synchronous active-low reset
//   i_mode[1:0]       output format, sampled when a byte leaves the FIFO
//   i_in_valid        one-cycle strobe qualifying i_in_data
//   i_in_data[7:0]    received byte
//   i_tx_rdy          transmitter idle
//   o_tx_en           one-cycle start pulse to the transmitter
//   o_tx_data[7:0]    character to send, valid while o_tx_en = 1
//   o_rx_count        in_valid strobes seen (wraps)
//   o_drop_count      bytes lost to overflow (saturates at 255)
//   o_fifo_level      current FIFO occupancy
module uart_stream_fmt #(
  parameter int DEPTH          = 16,
  parameter int BYTES_PER_LINE = 8,
  parameter int CNT_W          = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [1:0]               i_mode,
  input  logic                     i_in_valid,
  input  logic [7:0]               i_in_data,
  input  logic                     i_tx_rdy,
  output logic                     o_tx_en,
  output logic [7:0]               o_tx_data,
  output logic [CNT_W-1:0]         o_rx_count,
  output logic [7:0]               o_drop_count,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT_LOW, S_WAIT_HIGH} state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_level;
  logic [CNT_W-1:0] r_rx_count;
  logic [7:0]       r_drop_count;

  state_t           r_state;
  logic [7:0]       r_byte;
  logic [1:0]       r_idx;
  logic [1:0]       r_last;     // index of the final character; 0 means raw
  logic             r_crlf;     // this byte ends a line (mode 2)
  logic [LW-1:0]    r_line_cnt;
  logic             r_tx_en;
  logic [7:0]       r_tx_data;

  logic             w_full, w_empty, w_pop, w_push, w_drop, w_line_end;
  logic [7:0]       w_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
`ifdef HEX_LOWER_EN
    return 8'h57 + {4'h0, n};
`else
    return 8'h37 + {4'h0, n};
`endif
  endfunction

  assign w_full     = (r_level == (AW+1)'(DEPTH));
  assign w_empty    = (r_level == '0);
  // A byte is held in the FIFO until the transmitter is idle. This keeps
  // o_fifo_level an honest measure of the backlog while the line is stalled.
  assign w_pop      = (r_state == S_IDLE) && !w_empty && i_tx_rdy;
  assign w_push     = i_in_valid && (!w_full || w_pop);
  assign w_drop     = i_in_valid && !w_push;
  assign w_line_end = (r_line_cnt == LW'(BYTES_PER_LINE-1));

  // FIFO storage has no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_rx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
      if (i_in_valid) r_rx_count <= r_rx_count + 1'b1;
      if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  // Character for the current sequence index.
  always_comb begin
    w_char = r_byte;
    if (r_last != 2'd0) begin
      case (r_idx)
        2'd0:    w_char = hex_char(r_byte[7:4]);
        2'd1:    w_char = hex_char(r_byte[3:0]);
        2'd2:    w_char = r_crlf ? 8'h0D : 8'h20;
        default: w_char = 8'h0A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_crlf     <= 1'b0;
      r_line_cnt <= '0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_byte  <= r_mem[r_rd_ptr];
          r_idx   <= '0;
          r_crlf  <= 1'b0;
          r_state <= S_LOAD;
          // The separator and line position are fixed when the byte is popped.
          case (i_mode)
            2'd1: r_last <= 2'd2;
            2'd2: begin
              if (w_line_end) begin
                r_last     <= 2'd3;
                r_crlf     <= 1'b1;
                r_line_cnt <= '0;
              end else begin
                r_last     <= 2'd2;
                r_line_cnt <= r_line_cnt + 1'b1;
              end
            end
            default: r_last <= 2'd0;
          endcase
        end
        S_LOAD: begin
          r_tx_data <= w_char;
          r_state   <= S_ARM;
        end
        S_ARM: if (i_tx_rdy) begin
          r_tx_en <= 1'b1;
          r_state <= S_WAIT_LOW;
        end
        // tx_rdy is still high while the start pulse is in flight. Wait for the
        // transmitter to go busy before looking for idle again.
        S_WAIT_LOW: if (!i_tx_rdy) r_state <= S_WAIT_HIGH;
        S_WAIT_HIGH: if (i_tx_rdy) begin
          if (r_idx == r_last) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_en      = r_tx_en;
  assign o_tx_data    = r_tx_data;
  assign o_rx_count   = r_rx_count;
  assign o_drop_count = r_drop_count;
  assign o_fifo_level = r_level;

endmodule

// File: tb/tb_uart_stream_fmt.sv
// Directed bench for uart_stream_fmt with DEPTH=4, BYTES_PER_LINE=2 and CNT_W=4.
// A small transmitter model goes busy for 3 cycles after each start pulse
// and records every character sent.
module tb_uart_stream_fmt;
  localparam int DEPTH = 4;
  localparam int BPL   = 2;
  localparam int CNT_W = 4;
`ifdef HEX_LOWER_EN
  localparam logic [7:0] LA = 8'h61;
`else
  localparam logic [7:0] LA = 8'h41;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             tx_rdy;
  logic             tx_en;
  logic [7:0]       tx_data;
  logic [CNT_W-1:0] rx_count;
  logic [7:0]       drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  logic       hold = 1'b0;
  int         busy = 0;
  logic [7:0] cap[$];
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  din;
    int          n;
    logic [31:0] exp;   // first character in [31:24]
  } vec_t;
  vec_t tbl[9];

  uart_stream_fmt #(.DEPTH(DEPTH), .BYTES_PER_LINE(BPL), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_in_valid(in_valid),
    .i_in_data(in_data), .i_tx_rdy(tx_rdy), .o_tx_en(tx_en), .o_tx_data(tx_data),
    .o_rx_count(rx_count), .o_drop_count(drop_count), .o_fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  assign tx_rdy = !hold && (busy == 0);

  always @(posedge clk) begin
    if (tx_en) begin
      cap.push_back(tx_data);
      checks++;
      if (!tx_rdy) begin
        errors++;
        $display("FAIL tx_en_while_busy: tx_rdy=%0b required 1", tx_rdy);
      end
      busy <= 3;
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    mode = m; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_chars(input int n, input string name);
    int t;
    t = 0;
    while (cap.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cap.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d chars expected %0d", name, cap.size(), n);
    end
  endtask

  function automatic int cap_at(input int i);
    if (i < cap.size()) return int'(cap[i]);
    return -1;
  endfunction

  initial begin
    tbl[0] = '{2'd0, 8'h41, 1, {8'h41, 24'h0}};
    tbl[1] = '{2'd3, 8'h7E, 1, {8'h7E, 24'h0}};
    tbl[2] = '{2'd1, 8'h3A, 3, {8'h33, LA, 8'h20, 8'h00}};
    tbl[3] = '{2'd1, 8'h00, 3, 32'h30302000};
    tbl[4] = '{2'd2, 8'h01, 3, 32'h30312000};
    tbl[5] = '{2'd2, 8'h02, 4, 32'h30320D0A};
    tbl[6] = '{2'd2, 8'hFF, 3, {LA + 8'd5, LA + 8'd5, 8'h20, 8'h00}};
    tbl[7] = '{2'd1, 8'hC5, 3, {LA + 8'd2, 8'h35, 8'h20, 8'h00}};
    tbl[8] = '{2'd2, 8'h9B, 4, {8'h39, LA + 8'd1, 8'h0D, 8'h0A}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_fifo_level", fifo_level, 0);
    rst_n = 1'b1;

    // Latency: byte sampled at edge E0, start pulse visible after edge E3
    push_byte(2'd0, 8'h55);
    chk("lat_level_e0", fifo_level, 1);
    chk("lat_en_e0", tx_en, 0);
    @(negedge clk); chk("lat_en_e1", tx_en, 0);
    @(negedge clk); chk("lat_en_e2", tx_en, 0);
    @(negedge clk); chk("lat_en_e3", tx_en, 1);
    chk("lat_data_e3", tx_data, 8'h55);
    wait_chars(1, "lat");
    repeat (8) @(negedge clk);
    chk("lat_count", cap.size(), 1);
    chk("lat_rx_count", rx_count, 1);

    // Table: raw, reserved, hex and line-break modes (the line counter carries over)
    for (int v = 0; v < 9; v++) begin
      cap.delete();
      push_byte(tbl[v].mode, tbl[v].din);
      wait_chars(tbl[v].n, $sformatf("vec%0d", v));
      repeat (8) @(negedge clk);
      chk($sformatf("vec%0d_count", v), cap.size(), tbl[v].n);
      for (int c = 0; c < tbl[v].n; c++)
        chk($sformatf("vec%0d_char%0d", v, c), cap_at(c), int'(tbl[v].exp[31-8*c -: 8]));
    end
    chk("tbl_rx_count", rx_count, 10);
    chk("tbl_fifo_level", fifo_level, 0);

    // Overflow: the transmitter is stalled and DEPTH+3 bytes arrive
    do_reset();
    cap.delete();
    hold = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) push_byte(2'd0, 8'h10 + 8'(i));
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_drop", drop_count, 3);
    chk("ovf_rx", rx_count, (DEPTH + 3) % (1 << CNT_W));
    hold = 1'b0;
    wait_chars(DEPTH, "ovf");
    repeat (8) @(negedge clk);
    chk("ovf_count", cap.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("ovf_char%0d", i), cap_at(i), 8'h10 + i);
    chk("ovf_level_end", fifo_level, 0);

    // FIFO full: a push and a pop in the same cycle
    do_reset();
    cap.delete();
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(2'd0, 8'h20 + 8'(i));
    chk("full_level", fifo_level, DEPTH);
    @(negedge clk);
    hold = 1'b0; in_data = 8'h24; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_level", fifo_level, DEPTH);
    chk("pp_drop", drop_count, 0);
    chk("pp_rx", rx_count, DEPTH + 1);
    wait_chars(DEPTH + 1, "pp");
    repeat (8) @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) chk($sformatf("pp_char%0d", i), cap_at(i), 8'h20 + i);
    chk("pp_level_end", fifo_level, 0);

    // Reset in the middle of a hex sequence
    do_reset();
    cap.delete();
    push_byte(2'd1, 8'hA7);
    wait_chars(1, "mid");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_tx_en", tx_en, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_rx", rx_count, 0);
    chk("mid_drop", drop_count, 0);
    chk("mid_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_count", cap.size(), 1);
    chk("mid_char0", cap_at(0), LA);
    cap.delete();
    push_byte(2'd1, 8'h5C);
    wait_chars(3, "restart");
    repeat (8) @(negedge clk);
    chk("restart_count", cap.size(), 3);
    chk("restart_char0", cap_at(0), 8'h35);
    chk("restart_char1", cap_at(1), LA + 8'd2);
    chk("restart_char2", cap_at(2), 8'h20);
    chk("restart_rx", rx_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_stream_fmt.md
Name: uart_stream_fmt

Overview:
Buffered byte-stream formatter between a uart_rx-style receiver and a uart_tx-style transmitter. Received bytes go into a parametrised FIFO. They are then emitted as raw echo, as space-separated ASCII hex, or as ASCII hex with a CR/LF every BYTES_PER_LINE bytes. It also provides receive and drop counters for LEDs and debug. It is the buffered, multi-mode successor to the single-byte hex converter used in the loopback top.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
BYTES_PER_LINE, 8, bytes per line in mode 2; minimum 1
CNT_W, 4, width of rx_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
mode  in  2  0 = raw, 1 = hex + space, 2 = hex + line break, 3 = reserved (behaves as 0)
in_valid  in  1  one-cycle pulse; in_data is valid in that cycle
in_data  in  8  received byte
tx_rdy  in  1  transmitter idle
tx_en  out  1  one-cycle start pulse to transmitter
tx_data  out  8  character to send; valid while tx_en = 1
rx_count  out  CNT_W  number of in_valid pulses seen; wraps
drop_count  out  8  bytes lost to overflow; saturates at 255
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - tx_en = 0, tx_data = 0, rx_count = 0, drop_count = 0, fifo_level = 0.
  - FIFO empty, line counter = 0, formatter state IDLE.
  - Reset mid-sequence aborts the sequence; the pending character is not sent.
- FIFO:
  - A push occurs when in_valid = 1 and either (level < DEPTH) or (level = DEPTH and a pop happens in the same cycle).
  - When in_valid = 1, level = DEPTH and there is no pop, the byte is dropped and drop_count increments, saturating at 255.
  - rx_count increments on every in_valid pulse, including dropped bytes.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves level unchanged.
- Formatter states:
  - IDLE: if the FIFO is non-empty, pop the head byte and latch it together with mode, then go to LOAD. Mode is sampled only at pop time; changes mid-sequence have no effect until the next byte.
  - LOAD: select the current character of the sequence, drive tx_data, go to ARM.
  - ARM: when tx_rdy = 1, assert tx_en for exactly one cycle, go to WAIT_LOW.
  - WAIT_LOW: wait until tx_rdy = 0, then go to WAIT_HIGH. tx_rdy is never trusted on the cycle after tx_en.
  - WAIT_HIGH: wait until tx_rdy = 1. If more characters remain, advance the index and go to LOAD; otherwise go to IDLE.
- Character sequences:
  - Mode 0/3: the byte itself.
  - Mode 1: hex high nibble, hex low nibble, 0x20.
  - Mode 2: hex high nibble, hex low nibble, then a separator chosen by the line counter:
    - line counter = BYTES_PER_LINE-1: 0x0D, 0x0A, and the line counter resets to 0.
    - otherwise: 0x20, and the line counter increments.
  - The line counter changes only for mode 2 bytes.
- Hex digits: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46, or lowercase per the optional feature.
- Latency: in_valid in cycle N with the FIFO empty, state IDLE and tx_rdy = 1 gives tx_en = 1 in cycle N+3.
  - N+1: pop.
  - N+2: LOAD.
  - N+3: ARM fires.
- tx_en is never asserted while tx_rdy = 0.
- Characters leave strictly in FIFO order.

Optional Feature:
HEX_LOWER_EN
- Defined: hex digits 10-15 are emitted as 0x61-0x66 (a-f).
- Undefined: hex digits 10-15 are emitted as 0x41-0x46 (A-F).
- Raw mode is unaffected either way.

Test Plan:
- Raw echo: mode = 0, in_data = 0x41, tx_rdy model idle → exactly one tx_en with tx_data = 0x41; rx_count = 1.
- Hex mode: mode = 1, in_data = 0x3A → tx_data sequence 0x33, 0x41, 0x20. With HEX_LOWER_EN defined: 0x33, 0x61, 0x20.
- Line mode: BYTES_PER_LINE = 2, mode = 2, bytes 0x01, 0x02, 0xFF → 0x30, 0x31, 0x20, 0x30, 0x32, 0x0D, 0x0A, 0x46, 0x46, 0x20.
- Overflow:
  - Hold tx_rdy = 0 and push DEPTH+3 bytes → fifo_level = DEPTH, drop_count = 3, rx_count = (DEPTH+3) mod 2^CNT_W.
  - Release tx_rdy → the first DEPTH bytes are emitted in order and fifo_level returns to 0.
- Full plus simultaneous push/pop: FIFO full, pop and in_valid in the same cycle → byte accepted, level stays DEPTH, drop_count unchanged.
- Reset mid-sequence: mode = 1, assert rst_n = 0 after the first nibble's tx_en → tx_en stays 0, all counters and fifo_level read 0, and the next byte restarts cleanly from its high nibble.
